// File: rtl/tmds_channel_decoder.sv
// TMDS receive channel: word-boundary hunt on control tokens with bitslip, then 10b->8b decode.
// Optional `TMDS_LOCK_LOSS_CNT_EN` adds a saturating lock_loss_cnt output.
module tmds_channel_decoder #(
    parameter int SEARCH_TIMEOUT = 2048,
    parameter int LOCK_CNT       = 8,
    parameter int SLIP_WAIT      = 16
) (
    input  logic       p_clk,
    input  logic       rstin,
    input  logic [9:0] din,
    output logic       bitslip,
    output logic       locked,
    output logic [7:0] dout,
    output logic       de,
    output logic       c0,
`ifdef TMDS_LOCK_LOSS_CNT_EN
    output logic       c1,
    output logic [7:0] lock_loss_cnt
`else
    output logic       c1
`endif
);

    localparam int TW = $clog2(SEARCH_TIMEOUT);
    localparam int CW = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
    localparam int SW = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(SEARCH_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(LOCK_CNT - 1);
    localparam logic [SW-1:0] SLIP_LAST  = SW'(SLIP_WAIT - 1);

    typedef enum logic [1:0] {ST_SEARCH, ST_SLIP, ST_LOCKED} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [CW-1:0]   ctrl_cnt_q, ctrl_cnt_d;
    logic [SW-1:0]   slip_cnt_q, slip_cnt_d;
    logic            bitslip_q, bitslip_d;
    logic            locked_q, locked_d;
    logic [7:0]      dout_q, dout_d;
    logic            de_q, de_d;
    logic            c0_q, c0_d;
    logic            c1_q, c1_d;

    logic            is_ctrl;
    logic [1:0]      tok_c;
    logic [7:0]      d_word;
    logic [7:0]      dec_data;

    always_comb begin
        is_ctrl = 1'b1;
        tok_c   = 2'b00;
        case (din)
            10'b1101010100: tok_c = 2'b00;
            10'b0010101011: tok_c = 2'b01;
            10'b0101010100: tok_c = 2'b10;
            10'b1010101011: tok_c = 2'b11;
            default: begin
                is_ctrl = 1'b0;
                tok_c   = 2'b00;
            end
        endcase
    end

    // Undo the transition-minimising XOR/XNOR chain after removing the DC-balance inversion.
    assign d_word      = din[9] ? ~din[7:0] : din[7:0];
    assign dec_data[0] = d_word[0];
    generate
        for (genvar gi = 1; gi < 8; gi++) begin : g_dec
            assign dec_data[gi] = din[8] ? (d_word[gi] ^ d_word[gi-1])
                                         : ~(d_word[gi] ^ d_word[gi-1]);
        end
    endgenerate

    always_ff @(posedge p_clk) begin
        if (rstin) begin
            state_q    <= ST_SEARCH;
            timer_q    <= '0;
            ctrl_cnt_q <= '0;
            slip_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            ctrl_cnt_q <= ctrl_cnt_d;
            slip_cnt_q <= slip_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        ctrl_cnt_d = ctrl_cnt_q;
        slip_cnt_d = slip_cnt_q;
        case (state_q)
            ST_SEARCH: begin
                timer_d    = timer_q + TW'(1);
                ctrl_cnt_d = is_ctrl ? ctrl_cnt_q + CW'(1) : '0;
                // Lock is checked first so a simultaneous timeout never slips.
                if (is_ctrl && (ctrl_cnt_q == CNT_LAST)) begin
                    state_d    = ST_LOCKED;
                    timer_d    = '0;
                    ctrl_cnt_d = '0;
                end else if (timer_q == TIMER_LAST) begin
                    state_d    = ST_SLIP;
                    timer_d    = '0;
                    ctrl_cnt_d = '0;
                    slip_cnt_d = '0;
                end
            end
            ST_SLIP: begin
                if (slip_cnt_q == SLIP_LAST) begin
                    state_d    = ST_SEARCH;
                    slip_cnt_d = '0;
                    timer_d    = '0;
                    ctrl_cnt_d = '0;
                end else begin
                    slip_cnt_d = slip_cnt_q + SW'(1);
                end
            end
            ST_LOCKED: begin
                if (is_ctrl) begin
                    timer_d = '0;
                end else if (timer_q == TIMER_LAST) begin
                    state_d    = ST_SEARCH;
                    timer_d    = '0;
                    ctrl_cnt_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d = ST_SEARCH;
            end
        endcase
    end

    always_comb begin
        bitslip_d = (state_q == ST_SEARCH) && (state_d == ST_SLIP);
        locked_d  = (state_d == ST_LOCKED);
        de_d      = 1'b0;
        dout_d    = 8'h00;
        c0_d      = 1'b0;
        c1_d      = 1'b0;
        if (state_q == ST_LOCKED) begin
            if (is_ctrl) begin
                {c1_d, c0_d} = tok_c;
            end else begin
                de_d   = 1'b1;
                dout_d = dec_data;
                c0_d   = c0_q;
                c1_d   = c1_q;
            end
        end
    end

    always_ff @(posedge p_clk) begin
        if (rstin) begin
            bitslip_q <= 1'b0;
            locked_q  <= 1'b0;
            dout_q    <= 8'h00;
            de_q      <= 1'b0;
            c0_q      <= 1'b0;
            c1_q      <= 1'b0;
        end else begin
            bitslip_q <= bitslip_d;
            locked_q  <= locked_d;
            dout_q    <= dout_d;
            de_q      <= de_d;
            c0_q      <= c0_d;
            c1_q      <= c1_d;
        end
    end

    assign bitslip = bitslip_q;
    assign locked  = locked_q;
    assign dout    = dout_q;
    assign de      = de_q;
    assign c0      = c0_q;
    assign c1      = c1_q;

`ifdef TMDS_LOCK_LOSS_CNT_EN
    logic [7:0] lock_loss_cnt_q, lock_loss_cnt_d;

    always_comb begin
        lock_loss_cnt_d = lock_loss_cnt_q;
        if ((state_q == ST_LOCKED) && (state_d == ST_SEARCH) && (lock_loss_cnt_q != 8'hFF)) begin
            lock_loss_cnt_d = lock_loss_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge p_clk) begin
        if (rstin) begin
            lock_loss_cnt_q <= 8'h00;
        end else begin
            lock_loss_cnt_q <= lock_loss_cnt_d;
        end
    end

    assign lock_loss_cnt = lock_loss_cnt_q;
`endif

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed + randomized bench for tmds_channel_decoder against a cycle-count reference model.
module tb_tmds_channel_decoder;

    localparam int SEARCH_TIMEOUT = 2048;
    localparam int LOCK_CNT       = 8;
    localparam int SLIP_WAIT      = 16;
    localparam int M_SEARCH = 0, M_SLIP = 1, M_LOCKED = 2;

    logic       p_clk = 1'b0;
    logic       rstin = 1'b1;
    logic [9:0] din   = 10'h000;
    logic       bitslip, locked, de, c0, c1;
    logic [7:0] dout;
`ifdef TMDS_LOCK_LOSS_CNT_EN
    logic [7:0] lock_loss_cnt;
`endif

    always #5 p_clk = ~p_clk;

    tmds_channel_decoder #(
        .SEARCH_TIMEOUT(SEARCH_TIMEOUT),
        .LOCK_CNT      (LOCK_CNT),
        .SLIP_WAIT     (SLIP_WAIT)
    ) dut (
        .p_clk        (p_clk),
        .rstin        (rstin),
        .din          (din),
        .bitslip      (bitslip),
        .locked       (locked),
        .dout         (dout),
        .de           (de),
        .c0           (c0),
`ifdef TMDS_LOCK_LOSS_CNT_EN
        .c1           (c1),
        .lock_loss_cnt(lock_loss_cnt)
`else
        .c1           (c1)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Token table indexed by its {c1,c0} value.
    logic [9:0] tokens [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};

    int         m_mode, m_run, m_age, m_settle, m_llc;
    logic       e_bitslip, e_locked, e_de, e_c0, e_c1;
    logic [7:0] e_dout;
    int         cyc;
    int         slip_seen;
    int         slip_at[$];

    function automatic logic [7:0] ref_decode(input logic [9:0] w);
        logic [7:0] d;
        logic [7:0] r;
        d    = w[9] ? ~w[7:0] : w[7:0];
        r[0] = d[0];
        for (int i = 1; i < 8; i++) r[i] = d[i] ^ d[i-1] ^ ~w[8];
        return r;
    endfunction

    task automatic model_step(input logic [9:0] w, input logic rst);
        bit tok;
        int code;
        tok  = 1'b0;
        code = 0;
        for (int i = 0; i < 4; i++) if (tokens[i] == w) begin tok = 1'b1; code = i; end
        if (rst) begin
            m_mode = M_SEARCH; m_run = 0; m_age = 0; m_settle = 0; m_llc = 0;
            e_bitslip = 0; e_locked = 0; e_de = 0; e_c0 = 0; e_c1 = 0; e_dout = 8'h00;
            return;
        end
        if (m_mode == M_LOCKED) begin
            if (tok) begin
                e_de = 0; e_dout = 8'h00; e_c0 = code[0]; e_c1 = code[1];
            end else begin
                e_de = 1; e_dout = ref_decode(w);
            end
        end else begin
            e_de = 0; e_dout = 8'h00; e_c0 = 0; e_c1 = 0;
        end
        e_bitslip = 0;
        case (m_mode)
            M_SEARCH: begin
                m_run = tok ? m_run + 1 : 0;
                m_age++;
                if (tok && m_run >= LOCK_CNT) begin
                    m_mode = M_LOCKED; m_age = 0;
                end else if (m_age >= SEARCH_TIMEOUT) begin
                    m_mode = M_SLIP; e_bitslip = 1; m_settle = 0; m_run = 0; m_age = 0;
                end
            end
            M_SLIP: begin
                m_settle++;
                if (m_settle >= SLIP_WAIT) begin
                    m_mode = M_SEARCH; m_age = 0; m_run = 0;
                end
            end
            default: begin
                if (tok) m_age = 0;
                else begin
                    m_age++;
                    if (m_age >= SEARCH_TIMEOUT) begin
                        m_mode = M_SEARCH; m_age = 0; m_run = 0;
                        if (m_llc < 255) m_llc++;
                    end
                end
            end
        endcase
        e_locked = (m_mode == M_LOCKED);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick(input logic [9:0] w, input logic rst);
        din   = w;
        rstin = rst;
        @(posedge p_clk);
        model_step(w, rst);
        #1;
        cyc++;
        if (bitslip === 1'b1) begin
            slip_seen++;
            slip_at.push_back(cyc);
        end
        chk("bitslip", {31'd0, bitslip}, {31'd0, e_bitslip});
        chk("locked",  {31'd0, locked},  {31'd0, e_locked});
        chk("de",      {31'd0, de},      {31'd0, e_de});
        chk("c0",      {31'd0, c0},      {31'd0, e_c0});
        chk("c1",      {31'd0, c1},      {31'd0, e_c1});
        chk("dout",    {24'd0, dout},    {24'd0, e_dout});
`ifdef TMDS_LOCK_LOSS_CNT_EN
        chk("lock_loss_cnt", {24'd0, lock_loss_cnt}, m_llc);
`endif
    endtask

    function automatic logic [9:0] rand_data();
        logic [9:0] w;
        w = 10'($urandom);
        for (int i = 0; i < 4; i++) if (tokens[i] == w) w = 10'b0100000000;
        return w;
    endfunction

    initial begin
        int n0;
        logic [9:0] w;

        // Reset state
        repeat (3) tick(10'h000, 1'b1);
        chk("rst_locked", {31'd0, locked}, 0);
        chk("rst_bitslip", {31'd0, bitslip}, 0);
        chk("rst_dout", {24'd0, dout}, 0);
        $display("txn: reset applied");

        // Lock on eight c1c0=00 tokens
        for (int i = 0; i < 8; i++) begin
            tick(tokens[0], 1'b0);
            chk("lockseq_de", {31'd0, de}, 0);
            if (i < 7) chk("lockseq_locked_early", {31'd0, locked}, 0);
        end
        chk("lock_after_8", {31'd0, locked}, 1);
        $display("txn: 8 tokens sent, locked=%0d", locked);

        // Data decode
        tick(10'b0100000000, 1'b0);
        chk("dec_00", {24'd0, dout}, 32'h00); chk("dec_00_de", {31'd0, de}, 1);
        $display("txn: din=0100000000 dout=%02h de=%0d", dout, de);
        tick(10'b1011111111, 1'b0);
        chk("dec_FE", {24'd0, dout}, 32'hFE); chk("dec_FE_de", {31'd0, de}, 1);
        $display("txn: din=1011111111 dout=%02h de=%0d", dout, de);
        tick(10'b0111111111, 1'b0);
        chk("dec_01", {24'd0, dout}, 32'h01); chk("dec_01_de", {31'd0, de}, 1);
        $display("txn: din=0111111111 dout=%02h de=%0d", dout, de);

        // Control tokens update c1c0, data holds them
        tick(tokens[1], 1'b0);
        chk("tok01", {30'd0, c1, c0}, 1); chk("tok01_de", {31'd0, de}, 0);
        $display("txn: token 01 c1c0=%0d%0d", c1, c0);
        tick(tokens[3], 1'b0);
        chk("tok11", {30'd0, c1, c0}, 3);
        $display("txn: token 11 c1c0=%0d%0d", c1, c0);
        tick(10'b0100000000, 1'b0);
        chk("hold11", {30'd0, c1, c0}, 3); chk("hold11_de", {31'd0, de}, 1);
        $display("txn: data after token c1c0=%0d%0d de=%0d", c1, c0, de);

        // Loss of lock after SEARCH_TIMEOUT data words, no bitslip
        tick(tokens[2], 1'b0);
        n0 = slip_seen;
        for (int i = 0; i < SEARCH_TIMEOUT; i++) begin
            tick(rand_data(), 1'b0);
            if (i == SEARCH_TIMEOUT - 2) chk("still_locked", {31'd0, locked}, 1);
        end
        chk("lock_lost", {31'd0, locked}, 0);
        chk("no_slip_on_loss", slip_seen - n0, 0);
`ifdef TMDS_LOCK_LOSS_CNT_EN
        chk("llc_one", {24'd0, lock_loss_cnt}, 1);
`endif
        $display("txn: %0d data words, locked=%0d", SEARCH_TIMEOUT, locked);

        // Bitslip cadence on constant data
        tick(10'h000, 1'b1);
        cyc = 0;
        slip_at.delete();
        for (int k = 1; k <= 4117; k++) tick(10'b0100000000, 1'b0);
        chk("slip_count", slip_at.size(), 2);
        if (slip_at.size() >= 2) begin
            chk("slip_first", slip_at[0], SEARCH_TIMEOUT);
            chk("slip_spacing", slip_at[1] - slip_at[0], SEARCH_TIMEOUT + SLIP_WAIT);
        end
        $display("txn: constant data, %0d bitslip pulses", slip_at.size());

        // Reset five cycles into SLIP, then relock
        tick(10'b0100000000, 1'b1);
        n0 = slip_seen;
        repeat (2) tick(10'b0100000000, 1'b0);
        for (int i = 0; i < 8; i++) tick(tokens[0], 1'b0);
        chk("relock", {31'd0, locked}, 1);
        chk("no_slip_after_rst", slip_seen - n0, 0);
        $display("txn: reset mid-slip, relock locked=%0d", locked);

        // Randomized bursts of tokens, data, long quiet runs and resets
        n0 = cyc;
        while (cyc - n0 < 20000) begin
            int kind;
            int len;
            kind = $urandom_range(0, 99);
            if (kind < 40) begin
                len = $urandom_range(1, 12);
                w = tokens[$urandom_range(0, 3)];
                repeat (len) tick(w, 1'b0);
            end else if (kind < 95) begin
                len = $urandom_range(1, 60);
                repeat (len) tick(($urandom_range(0, 9) == 0) ? tokens[$urandom_range(0, 3)] : rand_data(), 1'b0);
            end else if (kind < 98) begin
                repeat (SEARCH_TIMEOUT + 40) tick(rand_data(), 1'b0);
            end else begin
                tick(rand_data(), 1'b1);
            end
        end
        $display("txn: random phase done, %0d bitslip pulses total", slip_seen);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
